// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: PC owner, fetch request FSM and {pc, inst, is_c, prediction} queue.
// Optional JAL target prediction is compiled in with `define IFQ_JAL_PREDICT_EN.
module inst_fetch_queue #(
  parameter int          IFQ_DEPTH  = 8,
  parameter int          IFQ_ADDR_W = 3,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_dec_en,
  output logic [31:0] mem_dec_addr,
  input  logic        mem_dec_rdy,
  input  logic [31:0] mem_dec_data,
  input  logic        mem_dec_is_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_is_c,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_pc
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [IFQ_ADDR_W:0] DEPTH_C = (IFQ_ADDR_W+1)'(IFQ_DEPTH);

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           addr_q, addr_d;
  logic [IFQ_ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IFQ_ADDR_W:0]   count_q, count_d, count_after;
  logic                  push, pop, pred_taken;
  logic [31:0]           seq_pc, next_pc;

  logic [31:0] pc_mem   [IFQ_DEPTH];
  logic [31:0] inst_mem [IFQ_DEPTH];
  logic [31:0] ppc_mem  [IFQ_DEPTH];
  logic        isc_mem  [IFQ_DEPTH];
  logic        pt_mem   [IFQ_DEPTH];

  assign seq_pc = pc_q + (mem_dec_is_c ? 32'd2 : 32'd4);

`ifdef IFQ_JAL_PREDICT_EN
  logic [31:0] jal_imm;
  assign jal_imm    = {{12{mem_dec_data[31]}}, mem_dec_data[19:12], mem_dec_data[20],
                       mem_dec_data[30:21], 1'b0};
  assign pred_taken = (mem_dec_data[6:0] == 7'b1101111);
  assign next_pc    = pred_taken ? (pc_q + jal_imm) : seq_pc;
`else
  assign pred_taken = 1'b0;
  assign next_pc    = seq_pc;
`endif

  assign push       = (state_q == S_WAIT) && mem_dec_rdy;
  assign pop        = out_valid && out_ready;
  assign mem_dec_en = (state_q == S_WAIT);
  assign mem_dec_addr = addr_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_after = count_q + (IFQ_ADDR_W+1)'(push) - (IFQ_ADDR_W+1)'(pop);
    count_d     = count_q;
    if (flush) begin
      state_d = S_IDLE;
      pc_d    = flush_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      count_d = count_after;
      if (push) tail_d = tail_q + IFQ_ADDR_W'(1);
      if (pop)  head_d = head_q + IFQ_ADDR_W'(1);
      // A request is only launched when its slot is guaranteed, so a push never overflows.
      case (state_q)
        S_IDLE: begin
          if (count_after < DEPTH_C) begin
            state_d = S_WAIT;
            addr_d  = pc_q;
          end
        end
        S_WAIT: begin
          if (push) begin
            pc_d = next_pc;
            if (count_after < DEPTH_C) addr_d  = next_pc;
            else                       state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && push && !flush) begin
      pc_mem[tail_q]   <= pc_q;
      inst_mem[tail_q] <= mem_dec_data;
      isc_mem[tail_q]  <= mem_dec_is_c;
      pt_mem[tail_q]   <= pred_taken;
      ppc_mem[tail_q]  <= next_pc;
    end
  end

  // Storage is not reset; an empty queue reads as zeros.
  assign out_valid      = (count_q != '0);
  assign out_pc         = out_valid ? pc_mem[head_q]   : '0;
  assign out_inst       = out_valid ? inst_mem[head_q] : '0;
  assign out_is_c       = out_valid ? isc_mem[head_q]  : 1'b0;
  assign out_pred_taken = out_valid ? pt_mem[head_q]   : 1'b0;
  assign out_pred_pc    = out_valid ? ppc_mem[head_q]  : '0;

endmodule
